// File: rtl/ro_freq_meter.sv
// Multi-channel ring-oscillator frequency meter.
// Counts synchronised rising edges of each channel over a gate window of clk cycles.
module ro_freq_meter #(
    parameter  int NUM_CH   = 4,
    parameter  int CNT_W    = 16,
    parameter  int GATE_W   = 12,
    parameter  int SYNC_STG = 2,
    localparam int SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              cont_mode,
    input  logic [GATE_W-1:0] gate_cycles,
    input  logic [NUM_CH-1:0] osc_in,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  rd_count,
    output logic              rd_ovf,
    output logic              ovf_any
);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [GATE_W-1:0] GATE_ONE = GATE_W'(1);

    state_t              state;
    logic [GATE_W-1:0]   timer;
    logic                busy_r;
    logic                done_r;

    logic [SYNC_STG-1:0] sync_q [NUM_CH];
    logic [NUM_CH-1:0]   sync_last;
    logic [NUM_CH-1:0]   hist_q;
    logic [NUM_CH-1:0]   osc_edge;

    logic [CNT_W-1:0]    cnt_q    [NUM_CH];
    logic [CNT_W-1:0]    result_q [NUM_CH];
    logic [NUM_CH-1:0]   run_ovf_q;
    logic [NUM_CH-1:0]   ovf_q;

    logic                counting;
    logic                last_cyc;
    logic                gate_ok;

    // Last synchroniser stage of each channel and its rising-edge strobe.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            sync_last[i] = sync_q[i][SYNC_STG-1];
        end
        osc_edge = sync_last & ~hist_q;
    end

    // Window qualifiers: a window ends normally only when not aborted.
    always_comb begin
        counting = (state == COUNT) && !stop;
        last_cyc = counting && (timer == GATE_ONE);
        gate_ok  = (gate_cycles != '0);
    end

    // Metastability chain per channel followed by one history flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                sync_q[i] <= '0;
            end
            hist_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (SYNC_STG > 1) begin
                    sync_q[i] <= {sync_q[i][SYNC_STG-2:0], osc_in[i]};
                end else begin
                    sync_q[i] <= SYNC_STG'(osc_in[i]);
                end
            end
            hist_q <= sync_last;
        end
    end

    // Control FSM: gate timer, busy flag and done pulse, all registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            timer  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && !stop && gate_ok) begin
                        state  <= COUNT;
                        timer  <= gate_cycles;
                        busy_r <= 1'b1;
                    end
                end
                COUNT: begin
                    if (stop) begin
                        state  <= IDLE;
                        timer  <= '0;
                        busy_r <= 1'b0;
                    end else if (timer == GATE_ONE) begin
                        done_r <= 1'b1;
                        if (cont_mode && gate_ok) begin
                            timer <= gate_cycles;
                        end else begin
                            state  <= IDLE;
                            timer  <= '0;
                            busy_r <= 1'b0;
                        end
                    end else begin
                        timer <= timer - GATE_ONE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    timer  <= '0;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    // Saturating edge counters; results and overflow flags latch on the final cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]    <= '0;
                result_q[i] <= '0;
            end
            run_ovf_q <= '0;
            ovf_q     <= '0;
        end else if (last_cyc) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (cnt_q[i] == CNT_MAX) begin
                    result_q[i] <= CNT_MAX;
                    ovf_q[i]    <= run_ovf_q[i] | osc_edge[i];
                end else begin
                    result_q[i] <= cnt_q[i] + CNT_W'(osc_edge[i]);
                    ovf_q[i]    <= run_ovf_q[i];
                end
                cnt_q[i] <= '0;
            end
            run_ovf_q <= '0;
        end else if (counting) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (osc_edge[i]) begin
                    if (cnt_q[i] == CNT_MAX) begin
                        run_ovf_q[i] <= 1'b1;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                    end
                end
            end
        end else begin
            // Idle or aborted window: counters restart from zero next time.
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
            run_ovf_q <= '0;
        end
    end

    // Result readback mux; out-of-range selects read zero.
    always_comb begin
        rd_count = '0;
        rd_ovf   = 1'b0;
        if (int'(rd_sel) < NUM_CH) begin
            rd_count = result_q[rd_sel];
            rd_ovf   = ovf_q[rd_sel];
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign ovf_any = |ovf_q;

endmodule

// File: tb/tb_ro_freq_meter.sv
// Testbench for ro_freq_meter: directed table, corner sequences and a
// randomised run checked against an edge-counting reference model.
module tb_ro_freq_meter;

    localparam int SYNC = 2;
    localparam int MAXC = 40000;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       cont_mode;
    logic [11:0] gate_cycles;
    logic [3:0] osc;
    logic [1:0] rd_sel;

    logic        busy, done, rd_ovf, ovf_any;
    logic [15:0] rd_count;
    logic        busy4, done4, rd_ovf4, ovf_any4;
    logic [3:0]  rd_count4;

    ro_freq_meter #(.NUM_CH(4), .CNT_W(16), .GATE_W(12), .SYNC_STG(SYNC)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .cont_mode(cont_mode), .gate_cycles(gate_cycles), .osc_in(osc),
        .rd_sel(rd_sel), .busy(busy), .done(done), .rd_count(rd_count),
        .rd_ovf(rd_ovf), .ovf_any(ovf_any)
    );

    ro_freq_meter #(.NUM_CH(3), .CNT_W(4), .GATE_W(12), .SYNC_STG(SYNC)) dut4 (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .cont_mode(cont_mode), .gate_cycles(gate_cycles), .osc_in(osc[2:0]),
        .rd_sel(rd_sel), .busy(busy4), .done(done4), .rd_count(rd_count4),
        .rd_ovf(rd_ovf4), .ovf_any(ovf_any4)
    );

    always #5 clk = ~clk;

    typedef struct {
        int per[4];
        int gate;
        int ex[4];
        int ex4[3];
        bit ov4[3];
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int per[4];
    int ph[4];
    logic [3:0] osch [0:MAXC];
    int s_start;

    task automatic chk(input string nm, input longint act, input longint ex);
        n_chk++;
        if (act != ex) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, ex);
        end
    endtask

    task automatic drive_osc();
        for (int c = 0; c < 4; c++) begin
            if (per[c] >= 2) osc[c] = (((cyc + ph[c]) % per[c]) < per[c] / 2);
            else osc[c] = 1'b0;
        end
        if (cyc <= MAXC) osch[cyc] = osc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        drive_osc();
    endtask

    // Reference: count rising edges of the ideal input waveform, shifted by
    // the synchroniser delay, over the G counting cycles after start.
    function automatic int model(input int s, input int g, input int c);
        int k = 0;
        for (int n = s + 1; n <= s + g; n++) begin
            if (osch[n-SYNC][c] && !osch[n-SYNC-1][c]) k++;
        end
        return k;
    endfunction

    task automatic check_results(input string nm, input int ex[4],
                                 input int ex4[3], input bit ov4[3]);
        bit any4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd_sel = 2'(i);
            #1;
            chk({nm, "_cnt"}, rd_count, ex[i]);
            chk({nm, "_ovf"}, rd_ovf, 0);
            if (i < 3) begin
                chk({nm, "_cnt4"}, rd_count4, ex4[i]);
                chk({nm, "_ovf4"}, rd_ovf4, ov4[i]);
                any4 |= ov4[i];
            end else begin
                chk({nm, "_sel_oor_cnt4"}, rd_count4, 0);
                chk({nm, "_sel_oor_ovf4"}, rd_ovf4, 0);
            end
        end
        chk({nm, "_ovf_any"}, ovf_any, 0);
        chk({nm, "_ovf_any4"}, ovf_any4, any4);
    endtask

    // One non-continuous window; checks busy span and done latency.
    task automatic measure(input int g);
        int rel;
        bit ok;
        s_start = cyc;
        gate_cycles = 12'(g);
        start = 1'b1;
        tick();
        start = 1'b0;
        rel = 1;
        ok = 1'b1;
        while (!done && rel <= g + 5) begin
            if (!busy || !busy4) ok = 1'b0;
            tick();
            rel++;
        end
        chk("done_latency", rel, g + 1);
        chk("busy_window", ok, 1);
        chk("busy_after", busy, 0);
        chk("done4_sync", done4, 1);
    endtask

    vec_t tbl[4];
    int ex[4];
    int ex4[3];
    bit ov4[3];
    int z4[3];
    bit zb[3];

    initial begin
        int dq[$];
        int rq[$];
        int nd;
        bit ok;

        tbl[0] = '{per: '{4, 10, 0, 2}, gate: 100, ex: '{25, 10, 0, 50},
                   ex4: '{15, 10, 0}, ov4: '{1, 0, 0}};
        tbl[1] = '{per: '{2, 10, 4, 0}, gate: 100, ex: '{50, 10, 25, 0},
                   ex4: '{15, 10, 15}, ov4: '{1, 0, 1}};
        tbl[2] = '{per: '{10, 10, 10, 10}, gate: 100, ex: '{10, 10, 10, 10},
                   ex4: '{10, 10, 10}, ov4: '{0, 0, 0}};
        tbl[3] = '{per: '{4, 4, 4, 4}, gate: 20, ex: '{5, 5, 5, 5},
                   ex4: '{5, 5, 5}, ov4: '{0, 0, 0}};
        z4 = '{0, 0, 0};
        zb = '{0, 0, 0};

        rst = 1'b1; start = 1'b0; stop = 1'b0; cont_mode = 1'b0;
        gate_cycles = '0; rd_sel = '0;
        for (int c = 0; c < 4; c++) begin per[c] = 0; ph[c] = 0; end
        drive_osc();
        repeat (3) tick();
        rst = 1'b0;
        ok = 1'b1;
        repeat (10) begin
            tick();
            if (busy || done) ok = 1'b0;
        end
        chk("reset_idle_busy_done", ok, 1);
        ex = '{0, 0, 0, 0};
        check_results("reset", ex, z4, zb);

        // Directed table
        for (int t = 0; t < 4; t++) begin
            for (int c = 0; c < 4; c++) per[c] = tbl[t].per[c];
            repeat (8) tick();
            measure(tbl[t].gate);
            check_results($sformatf("tbl%0d", t), tbl[t].ex, tbl[t].ex4, tbl[t].ov4);
        end

        // Continuous mode with gate change and mode clear
        for (int c = 0; c < 4; c++) per[c] = 4;
        repeat (5) tick();
        cont_mode = 1'b1;
        gate_cycles = 12'd20;
        rd_sel = 2'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        ok = 1'b1;
        for (int rel = 1; rel <= 95; rel++) begin
            if (done) begin dq.push_back(rel); rq.push_back(int'(rd_count)); end
            if (rel <= 80 && !busy) ok = 1'b0;
            if (rel > 81 && busy) ok = 1'b0;
            if (rel == 30) gate_cycles = 12'd40;
            if (rel == 60) cont_mode = 1'b0;
            tick();
        end
        chk("cont_busy", ok, 1);
        chk("cont_ndone", dq.size(), 3);
        if (dq.size() == 3) begin
            chk("cont_done0", dq[0], 21);
            chk("cont_done1", dq[1], 41);
            chk("cont_done2", dq[2], 81);
            chk("cont_res0", rq[0], 5);
            chk("cont_res1", rq[1], 5);
            chk("cont_res2", rq[2], 10);
        end

        // Abort on cycle 7 keeps previous results
        gate_cycles = 12'd50;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int rel = 1; rel < 7; rel++) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_busy", busy, 0);
        nd = 0;
        repeat (60) begin tick(); if (done) nd++; end
        chk("stop_no_done", nd, 0);
        ex = '{10, 10, 10, 10};
        ex4 = '{10, 10, 10};
        check_results("stop_hold", ex, ex4, zb);

        // start with stop, and start with zero gate, are ignored
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("start_stop_busy", busy, 0);
        gate_cycles = 12'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("gate0_busy", busy, 0);
        nd = 0;
        repeat (5) begin tick(); if (done || busy) nd++; end
        chk("ignored_quiet", nd, 0);

        // Reset mid-window in continuous mode
        cont_mode = 1'b1;
        gate_cycles = 12'd20;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cont_mode = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        ex = '{0, 0, 0, 0};
        check_results("rst_mid", ex, z4, zb);
        repeat (3) tick();
        measure(100);
        ex = '{25, 25, 25, 25};
        ex4 = '{15, 15, 15};
        ov4 = '{1, 1, 1};
        check_results("after_rst", ex, ex4, ov4);

        // Random periods, phases and gates against the edge model
        for (int r = 0; r < 20; r++) begin
            int g;
            for (int c = 0; c < 4; c++) begin
                per[c] = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(2, 16));
                ph[c] = int'($urandom_range(0, 15));
            end
            g = int'($urandom_range(1, 250));
            repeat (int'($urandom_range(4, 9))) tick();
            measure(g);
            for (int c = 0; c < 4; c++) ex[c] = model(s_start, g, c);
            for (int c = 0; c < 3; c++) begin
                ex4[c] = (ex[c] > 15) ? 15 : ex[c];
                ov4[c] = (ex[c] > 15);
            end
            check_results($sformatf("rand%0d", r), ex, ex4, ov4);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
